// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared types and codes for the multicycle ARM control unit:
//               FSM state enum, Op / cmd / ALUControl / Cond codes and the
//               ARM condition-code evaluation helper.
// Revision    : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // nzcv = {N,Z,C,V}; code 1111 evaluates false.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_cond_logic.sv
`default_nettype none
// ============================================================================
// Module      : mc_cond_logic
// Description : NZCV flag register, flag-write masking and the registered
//               condition-execute bit for the multicycle control unit.
// Ports       : clk, reset      clock, async active-high reset
//               cond            instruction condition field
//               alu_flags       {N,Z,C,V} from the ALU
//               flag_w          {write NZ, write CV} requests (unmasked)
//               latch_cond      capture cond_ex_q at the end of this cycle
//               cond_ex_q       condition result for the current instruction
// Revision    : 1.0  initial release
// ============================================================================
module mc_cond_logic
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       latch_cond,
  output logic       cond_ex_q
);

  logic [3:0] flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags     <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      if (latch_cond)
        cond_ex_q <= cond_holds(cond, flags);
      // A failed condition suppresses the flag update as well as the writes.
      if (flag_w[1] && cond_ex_q)
        flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] && cond_ex_q)
        flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_unit
// Description : Moore-style multicycle controller for the ARM core. Steps each
//               instruction through FETCH/DECODE/... and drives the datapath
//               enables and mux selects; holds NZCV via mc_cond_logic.
// Ports       : clk, reset                  clock, async active-high reset
//               Op, Funct, Rd, Cond         instruction fields
//               ALUFlags                    {N,Z,C,V} from the ALU
//               PCWrite/MemWrite/RegWrite/IRWrite  write enables
//               AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc  selects
//               ALUControl                  ALU command (ALUC_W bits)
// Revision    : 1.0  initial release
// ============================================================================
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALUC_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  output logic              PCWrite,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              IRWrite,
  output logic              AdrSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl
);

  localparam bit EXT_ALU = (ALUC_W >= 3);

  state_t     state;
  logic [3:0] cmd;
  logic [2:0] dp_alu;
  logic [2:0] alu_sel;
  logic       no_write;
  logic       reg_w, branch, ir_w, mem_w;
  logic       is_exec, arith_op, rd_pc;
  logic [1:0] flag_w;
  logic       cond_ex_q;

  assign cmd   = Funct[4:1];
  assign rd_pc = (Rd == 4'd15);

  // Data-processing command decode; unsupported commands become a harmless
  // ADD that never writes back.
  always_comb begin
    dp_alu   = ALU_ADD;
    no_write = 1'b0;
    case (cmd)
      CMD_ADD: dp_alu = ALU_ADD;
      CMD_SUB: dp_alu = ALU_SUB;
      CMD_AND: dp_alu = ALU_AND;
      CMD_ORR: dp_alu = ALU_ORR;
      CMD_CMP: begin dp_alu = ALU_SUB; no_write = 1'b1; end
      CMD_EOR: if (EXT_ALU) dp_alu = ALU_EOR; else no_write = 1'b1;
      CMD_MOV: if (EXT_ALU) dp_alu = ALU_MOV; else no_write = 1'b1;
      default: no_write = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_MEM:  state <= S_MEMADR;
            OP_DP:   state <= Funct[5] ? S_EXECI : S_EXECR;
            OP_BR:   state <= S_BRANCH;
            default: state <= S_FETCH;
          endcase
        end
        S_MEMADR: state <= Funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state <= S_MEMWB;
        S_EXECR,
        S_EXECI:  state <= S_ALUWB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_sel   = ALU_ADD;
    reg_w     = 1'b0;
    branch    = 1'b0;
    ir_w      = 1'b0;
    mem_w     = 1'b0;
    case (state)
      S_FETCH:  begin ir_w = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      S_DECODE: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWR:  begin AdrSrc = 1'b1; mem_w = 1'b1; end
      S_MEMWB:  begin ResultSrc = 2'b01; reg_w = 1'b1; end
      S_EXECR:  alu_sel = dp_alu;
      S_EXECI:  begin ALUSrcB = 2'b01; alu_sel = dp_alu; end
      S_ALUWB:  reg_w = ~no_write;
      S_BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
      default:  ;
    endcase
  end

  assign ALUControl = alu_sel[ALUC_W-1:0];

  // Reset forces the state to FETCH, whose selects are shown, but every write
  // enable is held off until reset is released.
  assign IRWrite  = ~reset & ir_w;
  assign MemWrite = ~reset & mem_w & cond_ex_q;
  assign RegWrite = ~reset & reg_w & cond_ex_q & ~rd_pc;
  assign PCWrite  = ~reset & ((state == S_FETCH) |
                              ((branch | (reg_w & rd_pc)) & cond_ex_q));

  assign ImmSrc = (Op == 2'b11) ? 2'b00 : Op;
  assign RegSrc = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BR)};

  // Arithmetic ops update all of NZCV; logical ops leave C and V alone.
  assign is_exec  = (state == S_EXECR) || (state == S_EXECI);
  assign arith_op = (dp_alu == ALU_ADD) || (dp_alu == ALU_SUB);
  assign flag_w   = {is_exec & Funct[0], is_exec & Funct[0] & arith_op};

  mc_cond_logic u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (Cond),
    .alu_flags  (ALUFlags),
    .flag_w     (flag_w),
    .latch_cond (state == S_DECODE),
    .cond_ex_q  (cond_ex_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_unit
// Description : Self-checking bench for mc_control_unit. Runs one instance per
//               ALU width side by side against an instruction-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Cond, ALUFlags;

  logic       pw2, mw2, rw2, iw2, as2, sa2;
  logic [1:0] sb2, rs2, im2, rg2, ac2;
  logic       pw3, mw3, rw3, iw3, as3, sa3;
  logic [1:0] sb3, rs3, im3, rg3;
  logic [2:0] ac3;

  mc_control_unit #(.ALUC_W(2)) dut2 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .PCWrite(pw2), .MemWrite(mw2), .RegWrite(rw2),
    .IRWrite(iw2), .AdrSrc(as2), .ALUSrcA(sa2), .ALUSrcB(sb2),
    .ResultSrc(rs2), .ImmSrc(im2), .RegSrc(rg2), .ALUControl(ac2));

  mc_control_unit #(.ALUC_W(3)) dut3 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .PCWrite(pw3), .MemWrite(mw3), .RegWrite(rw3),
    .IRWrite(iw3), .AdrSrc(as3), .ALUSrcA(sa3), .ALUSrcB(sb3),
    .ResultSrc(rs3), .ImmSrc(im3), .RegSrc(rg3), .ALUControl(ac3));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state per width (index 0: ALUC_W=2, index 1: ALUC_W=3).
  logic [3:0]  nz [2];
  logic        ce [2];
  logic [16:0] exp_v [2];
  logic [16:0] care_v [2];
  int          rw_cnt [2];
  int          pc_cnt [2];
  int          mw_cnt [2];
  logic [2:0]  last_ac [2];
  bit          use_fixed;
  logic [3:0]  fixed_fl;

  // Vector layout: [16]PCWrite [15]MemWrite [14]RegWrite [13]IRWrite
  // [12]AdrSrc [11]ALUSrcA [10:9]ALUSrcB [8:7]ResultSrc [6:5]ImmSrc
  // [4:3]RegSrc [2:0]ALUControl
  function automatic void dec(input logic [3:0] cmd, input int w,
                              output logic [2:0] a, output bit nw);
    a = 3'd0; nw = 1'b0;
    case (cmd)
      4'b0100: a = 3'd0;
      4'b0010: a = 3'd1;
      4'b0000: a = 3'd2;
      4'b1100: a = 3'd3;
      4'b1010: begin a = 3'd1; nw = 1'b1; end
      4'b0001: if (w == 1) a = 3'd4; else nw = 1'b1;
      4'b1101: if (w == 1) a = 3'd5; else nw = 1'b1;
      default: nw = 1'b1;
    endcase
  endfunction

  function automatic bit cond_ok(input logic [3:0] cd, input logic [3:0] f);
    bit n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cd[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (cd == 4'b1111) r = 1'b0;
    else if (cd[0] && cd[3:1] != 3'd7) r = !r;
    return r;
  endfunction

  function automatic int instr_len(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b00:   return 4;
      2'b01:   return f[0] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  task automatic set_exp(input int k, input bit rst);
    for (int w = 0; w < 2; w++) begin
      logic [16:0] e, c;
      logic [2:0]  a;
      bit          nw, ok, wr;
      logic [16:0] am;
      am = (w == 1) ? 17'h7 : 17'h3;
      e = '0;
      c = 17'h1E078;
      e[6:5] = (Op == 2'b11) ? 2'b00 : Op;
      e[4:3] = {Op == 2'b01 && !Funct[0], Op == 2'b10};
      dec(Funct[4:1], w, a, nw);
      ok = ce[w];
      if (rst || k == 0) begin
        e[11] = 1'b1; e[10:9] = 2'b10; e[8:7] = 2'b10;
        c = c | 17'h1F80 | am;
        if (!rst) begin e[16] = 1'b1; e[13] = 1'b1; end
      end else if (k == 1) begin
        e[11] = 1'b1; e[10:9] = 2'b10; e[8:7] = 2'b10;
        c = c | 17'h0F80 | am;
      end else if (Op == 2'b00) begin
        if (k == 2) begin
          e[10:9] = Funct[5] ? 2'b01 : 2'b00; e[2:0] = a;
          c = c | 17'h0E00 | am;
        end else begin
          wr = !nw && ok;
          e[14] = wr && (Rd != 4'd15);
          e[16] = wr && (Rd == 4'd15);
          c = c | 17'h0180;
        end
      end else if (Op == 2'b01) begin
        if (k == 2) begin
          e[10:9] = 2'b01; c = c | 17'h0E00 | am;
        end else if (k == 3) begin
          e[12] = 1'b1; c = c | 17'h1000;
          if (!Funct[0]) e[15] = ok;
        end else begin
          e[8:7] = 2'b01; c = c | 17'h0180;
          e[14] = ok && (Rd != 4'd15);
          e[16] = ok && (Rd == 4'd15);
        end
      end else begin
        e[10:9] = 2'b01; e[8:7] = 2'b10; c = c | 17'h0F80 | am;
        e[16] = ok;
      end
      exp_v[w]  = e;
      care_v[w] = c;
    end
  endtask

  task automatic cmp_cycle(input int k);
    logic [16:0] obs [2];
    obs[0] = {pw2, mw2, rw2, iw2, as2, sa2, sb2, rs2, im2, rg2, 1'b0, ac2};
    obs[1] = {pw3, mw3, rw3, iw3, as3, sa3, sb3, rs3, im3, rg3, ac3};
    for (int w = 0; w < 2; w++) begin
      total++;
      if (((obs[w] ^ exp_v[w]) & care_v[w]) != 17'h0) begin
        bad++;
        $display("FAIL ctrl_w%0d step=%0d op=%b funct=%b rd=%0d cond=%b got=%h need=%h care=%h",
                 w + 2, k, Op, Funct, Rd, Cond, obs[w], exp_v[w], care_v[w]);
      end
      if (obs[w][14]) rw_cnt[w]++;
      if (obs[w][16]) pc_cnt[w]++;
      if (obs[w][15]) mw_cnt[w]++;
      if (k == 2 && Op == 2'b00) last_ac[w] = obs[w][2:0];
    end
  endtask

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s got=%0h need=%0h", name, got, need);
    end
  endtask

  // Called at posedge+1 while an instruction is in flight.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    lit("rst_writes_w3", {4'h0, pw3, mw3, rw3, iw3}, 8'h0);
    lit("rst_writes_w2", {4'h0, pw2, mw2, rw2, iw2}, 8'h0);
    lit("rst_adrsrc", {7'h0, as3}, 8'h0);
    lit("rst_flags", {4'h0, dut3.u_cond.flags}, 8'h0);
    for (int w = 0; w < 2; w++) begin nz[w] = 4'h0; ce[w] = 1'b0; end
    for (int i = 0; i < 2; i++) begin
      set_exp(0, 1'b1);
      @(negedge clk); cmp_cycle(-1);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  // Entry and exit at posedge+1 with the DUT in FETCH (or mid-reset exit).
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic [3:0] cd,
                           input int abort_at);
    int len;
    logic [2:0] a;
    bit nw;
    Op = op; Funct = f; Rd = rd; Cond = cd;
    len = instr_len(op, f);
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) begin
        do_reset();
        return;
      end
      ALUFlags = use_fixed ? fixed_fl : 4'($urandom);
      set_exp(k, 1'b0);
      @(negedge clk); cmp_cycle(k);
      @(posedge clk);
      for (int w = 0; w < 2; w++) begin
        if (k == 1) ce[w] = cond_ok(cd, nz[w]);
        if (op == 2'b00 && k == 2 && f[0] && ce[w]) begin
          dec(f[4:1], w, a, nw);
          if (a <= 3'd1) nz[w] = ALUFlags;
          else nz[w][3:2] = ALUFlags[3:2];
        end
      end
      #1;
    end
  endtask

  int s_rw [2];
  int s_pc [2];
  int s_mw [2];

  task automatic snap();
    for (int w = 0; w < 2; w++) begin
      s_rw[w] = rw_cnt[w]; s_pc[w] = pc_cnt[w]; s_mw[w] = mw_cnt[w];
    end
  endtask

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'h0; Rd = 4'h0; Cond = 4'hE; ALUFlags = 4'h0;
    use_fixed = 1'b1; fixed_fl = 4'h0;
    for (int w = 0; w < 2; w++) begin
      nz[w] = 4'h0; ce[w] = 1'b0; rw_cnt[w] = 0; pc_cnt[w] = 0; mw_cnt[w] = 0;
      last_ac[w] = 3'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    lit("init_irwrite", {7'h0, iw3}, 8'h0);
    lit("init_pcwrite", {7'h0, pw2}, 8'h0);
    reset = 1'b0;

    // LDR aborted by reset in MEMRD
    run_instr(2'b01, 6'b000001, 4'd2, 4'hE, 3);

    // ADDS R1 with ALU flags Z=1
    fixed_fl = 4'b0100;
    snap(); run_instr(2'b00, 6'b001001, 4'd1, 4'hE, -1);
    lit("adds_regwrite", 8'(rw_cnt[1] - s_rw[1]), 8'd1);
    lit("adds_flags_w3", {4'h0, dut3.u_cond.flags}, 8'h04);
    lit("adds_flags_w2", {4'h0, dut2.u_cond.flags}, 8'h04);

    snap(); run_instr(2'b00, 6'b001000, 4'd1, 4'h0, -1);
    lit("addeq_z1_regwrite", 8'(rw_cnt[1] - s_rw[1]), 8'd1);

    fixed_fl = 4'b0000;
    run_instr(2'b00, 6'b001001, 4'd1, 4'hE, -1);
    snap(); run_instr(2'b00, 6'b001000, 4'd1, 4'h0, -1);
    lit("addeq_z0_regwrite", 8'(rw_cnt[1] - s_rw[1]), 8'd0);

    snap(); run_instr(2'b01, 6'b000001, 4'd2, 4'hE, -1);
    lit("ldr_regwrite", 8'(rw_cnt[1] - s_rw[1]), 8'd1);
    snap(); run_instr(2'b01, 6'b000000, 4'd2, 4'hE, -1);
    lit("str_memwrite", 8'(mw_cnt[1] - s_mw[1]), 8'd1);

    fixed_fl = 4'b0100;
    run_instr(2'b00, 6'b001001, 4'd1, 4'hE, -1);
    snap(); run_instr(2'b10, 6'b000000, 4'd0, 4'hE, -1);
    lit("b_al_pcwrite", 8'(pc_cnt[1] - s_pc[1]), 8'd2);
    snap(); run_instr(2'b10, 6'b000000, 4'd0, 4'h1, -1);
    lit("bne_z1_pcwrite", 8'(pc_cnt[1] - s_pc[1]), 8'd1);

    snap(); run_instr(2'b00, 6'b000010, 4'd3, 4'hE, -1);
    lit("eor_w3_aluctl", {5'h0, last_ac[1]}, 8'h04);
    lit("eor_w2_aluctl", {5'h0, last_ac[0]}, 8'h00);
    lit("eor_w3_regwrite", 8'(rw_cnt[1] - s_rw[1]), 8'd1);
    lit("eor_w2_regwrite", 8'(rw_cnt[0] - s_rw[0]), 8'd0);

    snap(); run_instr(2'b00, 6'b001000, 4'd15, 4'hE, -1);
    lit("rd15_pcwrite", 8'(pc_cnt[1] - s_pc[1]), 8'd2);
    lit("rd15_regwrite", 8'(rw_cnt[1] - s_rw[1]), 8'd0);

    // Randomized instruction stream
    use_fixed = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd, cd;
      int ab;
      op = 2'($urandom);
      f  = 6'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      cd = 4'($urandom);
      ab = ($urandom_range(0, 39) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(op, f, rd, cd, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
